// File: rtl/seq_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and iteration counts for the mul/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_ITER,
        DIV_ITER,
        FIX,
        DONE
    } state_t;

    // One Booth digit per cycle over WIDTH+2 extended multiplier bits; one quotient bit per cycle.
    function automatic int iter_count(input int width, input logic op);
        return (op == OP_DIV) ? width : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/seq_muldiv_booth_r4_recode.sv
// Radix-4 Booth recoder: 3-bit overlapping group -> {zero, neg, two} digit controls.
// Latency: combinational.
// Backpressure: none.
module booth_r4_recode (
    input  logic [2:0] grp,
    output logic       zero,
    output logic       neg,
    output logic       two
);

    // Digit map: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
    always_comb begin
        zero = (grp == 3'b000) || (grp == 3'b111);
        neg  = grp[2] & ~zero;
        two  = (grp == 3'b011) || (grp == 3'b100);
    end

endmodule

// File: rtl/seq_muldiv.sv
// Multi-cycle multiply (radix-4 Booth) / divide (non-restoring), signed or unsigned.
// Latency: MUL WIDTH/2+3, DIV WIDTH+2, DIV by zero 2 cycles from the accepting edge to done.
// Backpressure: start is only sampled while busy=0; starts during an operation are dropped.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               op_r, neg_q, neg_r, dz_r;
    logic [WIDTH-1:0]   a_r, quo;
    logic [2*WIDTH-1:0] mcand, acc, pp, acc_nxt;
    logic [WIDTH+2:0]   mplier;
    logic [WIDTH:0]     rem, dvsr, rem_sh, rem_step;
    logic [WIDTH-1:0]   rem_corr, q_final, r_final, mag_a, mag_b;
    logic               sa, sb, accept;
    logic               bz, bneg, btwo;

    assign accept = start & ~busy;
    assign sa     = signed_mode & a[WIDTH-1];
    assign sb     = signed_mode & b[WIDTH-1];
    assign mag_a  = sa ? (~a + 1'b1) : a;
    assign mag_b  = sb ? (~b + 1'b1) : b;

    // The multiplier register shifts right by two each cycle, so the live group is always bits [2:0].
    booth_r4_recode u_recode (
        .grp  (mplier[2:0]),
        .zero (bz),
        .neg  (bneg),
        .two  (btwo)
    );

    assign pp      = bz ? '0 : (btwo ? {mcand[2*WIDTH-2:0], 1'b0} : mcand);
    assign acc_nxt = bneg ? (acc - pp) : (acc + pp);

    // Non-restoring step; wraparound in WIDTH+1 bits is harmless since the true result fits.
    assign rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_step = rem[WIDTH] ? (rem_sh + dvsr) : (rem_sh - dvsr);
    assign rem_corr = rem[WIDTH] ? (rem[WIDTH-1:0] + dvsr[WIDTH-1:0]) : rem[WIDTH-1:0];
    assign q_final  = neg_q ? (~quo + 1'b1) : quo;
    assign r_final  = neg_r ? (~rem_corr + 1'b1) : rem_corr;

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status decode; DONE may re-launch directly for back-to-back operations.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    if (op == OP_MUL)  state_nxt = MUL_ITER;
                    else if (b == '0)  state_nxt = FIX;
                    else               state_nxt = DIV_ITER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MUL_ITER, DIV_ITER: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers (results load only on FIX -> DONE).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt         <= '0;
            op_r        <= OP_MUL;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_r        <= 1'b0;
            a_r         <= '0;
            quo         <= '0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            rem         <= '0;
            dvsr        <= '0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else if (accept) begin
            cnt         <= CW'(iter_count(WIDTH, op) - 1);
            op_r        <= op;
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            dz_r        <= (op == OP_DIV) && (b == '0);
            a_r         <= a;
            quo         <= mag_a;
            mcand       <= {{WIDTH{sa}}, a};
            acc         <= '0;
            mplier      <= {sb, sb, b, 1'b0};
            rem         <= '0;
            dvsr        <= {1'b0, mag_b};
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                MUL_ITER: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[2*WIDTH-3:0], 2'b00};
                    mplier <= {2'b00, mplier[WIDTH+2:2]};
                    cnt    <= cnt - 1'b1;
                end
                DIV_ITER: begin
                    rem <= rem_step;
                    quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    div_by_zero <= dz_r;
                    if (op_r == OP_MUL) begin
                        hi <= acc[2*WIDTH-1:WIDTH];
                        lo <= acc[WIDTH-1:0];
                    end else if (dz_r) begin
                        hi <= a_r;
                        lo <= '1;
                    end else begin
                        hi <= r_final;
                        lo <= q_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv at WIDTH=32 (directed) and WIDTH=8 (random vs arithmetic model).
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_muldiv;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        st32, op32, sm32, busy32, done32, dz32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        st8, op8, sm8, busy8, done8, dz8;
    logic [7:0]  a8, b8, hi8, lo8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        sel8 = 1'b0;
    logic        c_busy, c_done, c_dz;
    logic [31:0] c_hi, c_lo;
    logic [31:0] prev_hi [2];
    logic [31:0] prev_lo [2];

    always #5 clock = ~clock;

    seq_muldiv #(.WIDTH(32)) u_dut32 (
        .clock(clock), .clear(clear), .start(st32), .op(op32), .signed_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div_by_zero(dz32),
        .hi(hi32), .lo(lo32)
    );

    seq_muldiv #(.WIDTH(8)) u_dut8 (
        .clock(clock), .clear(clear), .start(st8), .op(op8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_by_zero(dz8),
        .hi(hi8), .lo(lo8)
    );

    // View of whichever instance the current test is driving.
    always_comb begin
        c_busy = sel8 ? busy8 : busy32;
        c_done = sel8 ? done8 : done32;
        c_dz   = sel8 ? dz8   : dz32;
        c_hi   = sel8 ? {24'h0, hi8} : hi32;
        c_lo   = sel8 ? {24'h0, lo8} : lo32;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic reference: returns {hi, lo} for a w-bit unit.
    function automatic logic [63:0] ref_model(input int w, input logic o, input logic sm,
                                              input logic [31:0] av, input logic [31:0] bv);
        longint      m, x, y;
        logic [63:0] p, t;
        logic [31:0] rh, rl;
        m = (longint'(1) << w) - 1;
        x = longint'(av);
        y = longint'(bv);
        if (sm && av[w-1]) x = x - (longint'(1) << w);
        if (sm && bv[w-1]) y = y - (longint'(1) << w);
        if (o == OP_MUL) begin
            p  = x * y;
            t  = p & m;
            rl = t[31:0];
            t  = (p >> w) & m;
            rh = t[31:0];
        end else if (bv == 0) begin
            rh = av;
            t  = m;
            rl = t[31:0];
        end else begin
            t  = (x / y) & m;
            rl = t[31:0];
            t  = (x % y) & m;
            rh = t[31:0];
        end
        return {rh, rl};
    endfunction

    task automatic drive(input logic s, input logic o, input logic sm,
                         input logic [31:0] av, input logic [31:0] bv);
        if (sel8) begin
            st8 = s; op8 = o; sm8 = sm; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            st32 = s; op32 = o; sm32 = sm; a32 = av; b32 = bv;
        end
    endtask

    // Launch one operation (optionally back-to-back with gap=0), poke start mid-op, check everything.
    task automatic run_op(input logic o, input logic sm, input logic [31:0] av_in,
                          input logic [31:0] bv_in, input int gap, input bit poke);
        int          w, idx, lat, n;
        bit          seen;
        logic [31:0] av, bv;
        logic [63:0] r;
        w   = sel8 ? 8 : 32;
        idx = sel8 ? 1 : 0;
        av  = sel8 ? (av_in & 32'hFF) : av_in;
        bv  = sel8 ? (bv_in & 32'hFF) : bv_in;
        r   = ref_model(w, o, sm, av, bv);
        lat = (o == OP_MUL) ? (w / 2 + 3) : ((bv == 0) ? 2 : (w + 2));
        n    = 0;
        seen = 1'b0;
        repeat (gap) @(negedge clock);
        drive(1'b1, o, sm, av, bv);
        while (!seen && n < 200) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                check_eq("busy_after_accept", 64'(c_busy), 64'd1);
                check_eq("dz_cleared", 64'(c_dz), 64'd0);
            end
            if (c_done) begin
                seen = 1'b1;
                check_eq("latency", 64'(n), 64'(lat));
                check_eq("busy_in_done", 64'(c_busy), 64'd0);
                check_eq("hi", 64'(c_hi), 64'(r[63:32]));
                check_eq("lo", 64'(c_lo), 64'(r[31:0]));
                check_eq("dz_flag", 64'(c_dz), 64'((o == OP_DIV) && (bv == 0)));
                prev_hi[idx] = r[63:32];
                prev_lo[idx] = r[31:0];
            end else begin
                check_eq("hold_hi", 64'(c_hi), 64'(prev_hi[idx]));
                check_eq("hold_lo", 64'(c_lo), 64'(prev_lo[idx]));
            end
            if (n == 1 && poke && !seen)
                drive(1'b1, ~o, ~sm, $urandom, $urandom);
            else
                drive(1'b0, o, sm, av, bv);
        end
        check_eq("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int          dones;
        logic        o, sm;
        logic [31:0] av, bv;

        clear = 1'b1;
        prev_hi[0] = '0; prev_lo[0] = '0; prev_hi[1] = '0; prev_lo[1] = '0;
        sel8 = 1'b1; drive(1'b0, OP_MUL, 1'b0, '0, '0);
        sel8 = 1'b0; drive(1'b0, OP_MUL, 1'b0, '0, '0);
        #12;
        check_eq("rst_busy", 64'(busy32), 64'd0);
        check_eq("rst_done", 64'(done32), 64'd0);
        check_eq("rst_dz", 64'(dz32), 64'd0);
        check_eq("rst_hi", 64'(hi32), 64'd0);
        check_eq("rst_lo", 64'(lo32), 64'd0);
        check_eq("rst_hilo8", 64'({hi8, lo8, busy8, done8, dz8}), 64'd0);
        @(negedge clock);
        clear = 1'b0;

        // WIDTH=32 directed cases.
        run_op(OP_MUL, 1'b1, 32'd7, 32'hFFFFFFFD, 1, 1'b0);
        check_eq("mul_s_hi", 64'(hi32), 64'hFFFFFFFF);
        check_eq("mul_s_lo", 64'(lo32), 64'hFFFFFFEB);
        run_op(OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        check_eq("mul_ones_hi", 64'(hi32), 64'hFFFFFFFE);
        check_eq("mul_ones_lo", 64'(lo32), 64'h00000001);
        run_op(OP_DIV, 1'b1, 32'hFFFFFFEF, 32'd5, 0, 1'b1);
        check_eq("div_s_lo", 64'(lo32), 64'hFFFFFFFD);
        check_eq("div_s_hi", 64'(hi32), 64'hFFFFFFFE);
        run_op(OP_DIV, 1'b0, 32'd100, 32'd7, 2, 1'b0);
        check_eq("div_u_lo", 64'(lo32), 64'd14);
        check_eq("div_u_hi", 64'(hi32), 64'd2);
        run_op(OP_DIV, 1'b0, 32'h12345678, 32'd0, 0, 1'b1);
        check_eq("dz_lo", 64'(lo32), 64'hFFFFFFFF);
        check_eq("dz_hi", 64'(hi32), 64'h12345678);
        run_op(OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1);
        check_eq("minneg_lo", 64'(lo32), 64'h80000000);
        check_eq("minneg_hi", 64'(hi32), 64'd0);
        run_op(OP_MUL, 1'b1, 32'd0, 32'h00001234, 1, 1'b1);
        run_op(OP_DIV, 1'b1, 32'hDEADBEEF, 32'd1234, 0, 1'b0);

        // Asynchronous clear in the middle of a divide.
        drive(1'b1, OP_DIV, 1'b1, 32'hFFFFFF00, 32'd3);
        @(negedge clock);
        drive(1'b0, OP_DIV, 1'b1, 32'hFFFFFF00, 32'd3);
        repeat (5) @(negedge clock);
        #2 clear = 1'b1;
        #1;
        check_eq("clr_busy", 64'(busy32), 64'd0);
        check_eq("clr_done", 64'(done32), 64'd0);
        check_eq("clr_dz", 64'(dz32), 64'd0);
        check_eq("clr_hi", 64'(hi32), 64'd0);
        check_eq("clr_lo", 64'(lo32), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        prev_hi[0] = '0; prev_lo[0] = '0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (done32) dones++;
        end
        check_eq("no_done_after_clr", 64'(dones), 64'd0);

        // WIDTH=8: directed repeats, then random operands against the model.
        sel8 = 1'b1;
        run_op(OP_MUL, 1'b1, 32'h07, 32'hFD, 1, 1'b0);
        run_op(OP_MUL, 1'b0, 32'hFF, 32'hFF, 0, 1'b0);
        run_op(OP_DIV, 1'b1, 32'hEF, 32'h05, 0, 1'b1);
        run_op(OP_DIV, 1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_op(OP_DIV, 1'b1, 32'h80, 32'hFF, 1, 1'b0);
        run_op(OP_DIV, 1'b0, 32'h5A, 32'h00, 0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            o  = 1'($urandom_range(0, 1));
            sm = 1'($urandom_range(0, 1));
            av = $urandom_range(0, 255);
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(0, 255);
            run_op(o, sm, av, bv, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
